// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and constants for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;
  localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side requests and memory-side bus of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 8);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_cancel;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_valid;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  modport slave (
    input  if_req, if_addr, if_cancel, d_req, d_we, d_funct3, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_valid, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, if_cancel, d_req, d_we, d_funct3, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_valid, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_fair_counter.sv
// arb_fair_counter: saturating count of consecutive data grants made while a fetch waits
module arb_fair_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_limit_o = cnt_q >= limit_i;
  // clear wins over increment; increment stops at the limit
  always_comb cnt_d = clr_i ? '0 : (inc_i && !at_limit_o) ? cnt_q + 1'b1 : cnt_q;
  // streak register, cleared by the active-low synchronous reset
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory between fetch and data with bounded data priority
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MAX_D_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              we_q, we_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic              d_elig, f_elig, grant_d, grant_f, at_limit;
  logic              unused_addr_hi;
  assign unused_addr_hi = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};
  arb_fair_counter #(.W(4)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (grant_d && bus.if_req),
    .clr_i      (grant_f || !bus.if_req),
    .limit_i    (4'(MAX_D_BURST)),
    .at_limit_o (at_limit)
  );
  // grant decision, transaction capture, completion and next state; no grant during an ack cycle
  always_comb begin
    d_elig     = bus.d_req && !d_ack_q;
    f_elig     = bus.if_req && !bus.if_cancel && !if_ack_q;
    grant_d    = state_q == IDLE && !if_ack_q && d_elig && (!f_elig || !at_limit);
    grant_f    = state_q == IDLE && !d_ack_q && f_elig && (!d_elig || at_limit);
    if_ack_d   = state_q == FETCH && bus.mem_ready && !bus.if_cancel;
    d_ack_d    = state_q == DATA && bus.mem_ready;
    if_rdata_d = if_ack_d ? bus.mem_rdata : if_rdata_q;
    d_rdata_d  = d_ack_d ? (we_q ? '0 : bus.mem_rdata) : d_rdata_q;
    addr_d     = grant_f ? bus.if_addr[ADDR_W-1:0] : grant_d ? bus.d_addr[ADDR_W-1:0] : addr_q;
    funct3_d   = grant_f ? FETCH_FUNCT3 : grant_d ? bus.d_funct3 : funct3_q;
    wdata_d    = grant_f ? '0 : grant_d ? bus.d_wdata : wdata_q;
    we_d       = grant_d ? bus.d_we : !grant_f && we_q;
    state_d    = state_q == IDLE ? (grant_f ? FETCH : grant_d ? DATA : IDLE)
               : bus.mem_ready ? IDLE
               : (state_q == FETCH && bus.if_cancel) ? DRAIN : state_q;
  end
  // state and registered bus outputs; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign bus.mem_valid  = state_q != IDLE;
  assign bus.mem_read   = state_q != IDLE && !we_q;
  assign bus.mem_write  = state_q != IDLE && we_q;
  assign bus.mem_funct3 = funct3_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a scoreboard of expected acks and grant order
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(8)) bus();
  mem_port_arbiter #(.ADDR_W(8), .MAX_D_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed { logic fetch; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic f_pend_q = 1'b0, d_pend_q = 1'b0;
  logic [31:0] f_addr_q, d_addr_q, d_wdata_q;
  logic d_we_q;
  // requester protocol: a pending request must stay asserted and stable until acked (fetch may be cancelled)
  always @(posedge clk) begin
    if (rst && f_pend_q && !bus.if_ack && !bus.if_cancel && (!bus.if_req || bus.if_addr !== f_addr_q))
      $error("protocol: fetch request dropped or changed while pending");
    if (rst && d_pend_q && !bus.d_ack && (!bus.d_req || bus.d_addr !== d_addr_q || bus.d_wdata !== d_wdata_q || bus.d_we !== d_we_q))
      $error("protocol: data request dropped or changed while pending");
    f_pend_q  <= rst && bus.if_req && !bus.if_ack && !bus.if_cancel;
    d_pend_q  <= rst && bus.d_req && !bus.d_ack;
    f_addr_q  <= bus.if_addr;
    d_addr_q  <= bus.d_addr;
    d_wdata_q <= bus.d_wdata;
    d_we_q    <= bus.d_we;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    n_cmp++;
    if ({bus.if_ack, bus.d_ack, bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0", {bus.if_ack, bus.d_ack, bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
    end
    n_cmp++;
    if (dut.state_q !== IDLE || dut.u_cnt.cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state got state=%0d streak=%0d want 0/0", dut.state_q, dut.u_cnt.cnt_q);
    end
    rst = 1'b1;
    cyc();
  endtask
  task automatic test_single_fetch();
    exp_t e;
    sb.delete();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    bus.if_addr   = 32'h10;
    bus.if_req    = 1'b1;
    sb.push_back(exp_t'{1'b1, 32'h0050_0093});
    cyc();
    n_cmp++;
    if ({bus.mem_valid, bus.mem_read, bus.mem_write} !== 3'b110 || bus.mem_addr !== 8'h10 || bus.mem_funct3 !== 3'b010 || bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c1 got v/r/w=%b addr=%h f3=%b ack=%b want 110 10 010 0", {bus.mem_valid, bus.mem_read, bus.mem_write}, bus.mem_addr, bus.mem_funct3, bus.if_ack);
    end
    cyc();
    n_cmp++;
    if (bus.if_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c2 got if_ack=%b d_ack=%b valid=%b want 1 0 0", bus.if_ack, bus.d_ack, bus.mem_valid);
    end
    if (bus.if_ack && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (!e.fetch || bus.if_rdata !== e.data) begin
        n_bad++;
        $display("FAIL fetch_rdata got %h want %h", bus.if_rdata, e.data);
      end
    end
    bus.if_req = 1'b0;
    cyc();
    bus.mem_ready = 1'b0;
    n_cmp++;
    if (bus.if_ack !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c3 got ack=%b valid=%b want 0 0", bus.if_ack, bus.mem_valid);
    end
    cyc();
  endtask
  task automatic test_load_wait();
    exp_t e;
    sb.delete();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h84;
    bus.d_funct3  = 3'b000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hA5A5_1234;
    sb.push_back(exp_t'{1'b0, 32'hA5A5_1234});
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c <= 4) begin
        n_cmp++;
        if (bus.mem_valid !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h84 || bus.mem_funct3 !== 3'b000 || bus.d_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL load_hold_c%0d got valid=%b read=%b addr=%h ack=%b want 1 1 84 0", c, bus.mem_valid, bus.mem_read, bus.mem_addr, bus.d_ack);
        end
      end
      if (c == 4) bus.mem_ready = 1'b1;
      if (c == 5) begin
        n_cmp++;
        if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL load_ack got d_ack=%b if_ack=%b want 1 0", bus.d_ack, bus.if_ack);
        end
        if (bus.d_ack && sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (e.fetch || bus.d_rdata !== e.data) begin
            n_bad++;
            $display("FAIL load_rdata got %h want %h", bus.d_rdata, e.data);
          end
        end
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
      end
    end
    repeat (2) cyc();
  endtask
  task automatic test_fairness();
    exp_t e;
    int got = 0;
    bit done = 0;
    bit prev_valid = 0;
    sb.delete();
    for (int i = 0; i < 10; i++) sb.push_back(exp_t'{i % 5 == 4, (i % 5 == 4) ? 32'h20 : 32'h40});
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h20;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h40;
    bus.d_we      = 1'b0;
    bus.d_funct3  = 3'b010;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0C0F_FEE0;
    for (int c = 0; c < 80 && !done; c++) begin
      cyc();
      n_cmp++;
      if (bus.if_ack && bus.d_ack) begin
        n_bad++;
        $display("FAIL fair_both_acks got if_ack=1 d_ack=1 want at most one");
      end
      if (bus.mem_valid && !prev_valid && got < 10 && sb.size() > 0) begin
        got++;
        e = sb.pop_front();
        n_cmp++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== e.data[7:0]) begin
          n_bad++;
          $display("FAIL fair_grant%0d got addr=%h want %h", got, bus.mem_addr, e.data[7:0]);
        end
      end
      prev_valid = bus.mem_valid;
      if (got == 10 && bus.if_ack) bus.if_req = 1'b0;
      if (!bus.if_req && bus.d_ack) begin
        bus.d_req = 1'b0;
        done = 1;
      end
    end
    n_cmp++;
    if (!done || got != 10) begin
      n_bad++;
      $display("FAIL fair_timeout got grants=%0d done=%0d want 10 1", got, done);
    end
    bus.mem_ready = 1'b0;
    repeat (2) cyc();
  endtask
  task automatic test_store_cancel();
    exp_t e;
    sb.delete();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h90;
    bus.d_wdata   = 32'hDEAD_BEEF;
    bus.d_funct3  = 3'b010;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h1234_5678;
    sb.push_back(exp_t'{1'b0, 32'h0});
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c <= 3) begin
        n_cmp++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 8'h90 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.d_ack !== 1'b0 || dut.state_q !== DATA) begin
          n_bad++;
          $display("FAIL store_hold_c%0d got w=%b r=%b addr=%h wdata=%h ack=%b want 1 0 90 deadbeef 0", c, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.d_ack);
        end
      end
      if (c == 1) bus.if_cancel = 1'b1;
      if (c == 2) bus.if_cancel = 1'b0;
      if (c == 3) bus.mem_ready = 1'b1;
      if (c == 4) begin
        n_cmp++;
        if (bus.d_ack !== 1'b1) begin
          n_bad++;
          $display("FAIL store_ack got %b want 1", bus.d_ack);
        end
        if (bus.d_ack && sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (bus.d_rdata !== e.data) begin
            n_bad++;
            $display("FAIL store_rdata got %h want %h", bus.d_rdata, e.data);
          end
        end
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
      end
    end
    repeat (2) cyc();
  endtask
  task automatic test_cancel();
    exp_t e;
    sb.delete();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    bus.if_addr   = 32'h30;
    bus.if_req    = 1'b1;
    sb.push_back(exp_t'{1'b0, 32'h0BAD_F00D});
    cyc();
    n_cmp++;
    if (dut.state_q !== FETCH || bus.mem_addr !== 8'h30) begin
      n_bad++;
      $display("FAIL cancel_c1 got state=%0d addr=%h want FETCH 30", dut.state_q, bus.mem_addr);
    end
    cyc();
    bus.if_cancel = 1'b1;
    bus.if_req    = 1'b0;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h50;
    bus.d_we      = 1'b0;
    bus.d_funct3  = 3'b100;
    cyc();
    n_cmp++;
    if (dut.state_q !== DRAIN || bus.mem_valid !== 1'b1 || bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_drain got state=%0d valid=%b ack=%b want DRAIN 1 0", dut.state_q, bus.mem_valid, bus.if_ack);
    end
    bus.if_cancel = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    n_cmp++;
    if (dut.state_q !== IDLE || bus.mem_valid !== 1'b0 || bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_c4 got state=%0d valid=%b if_ack=%b want IDLE 0 0", dut.state_q, bus.mem_valid, bus.if_ack);
    end
    cyc();
    n_cmp++;
    if (dut.state_q !== DATA || bus.mem_addr !== 8'h50 || bus.mem_funct3 !== 3'b100 || bus.mem_read !== 1'b1) begin
      n_bad++;
      $display("FAIL cancel_dgrant got state=%0d addr=%h f3=%b want DATA 50 100", dut.state_q, bus.mem_addr, bus.mem_funct3);
    end
    cyc();
    n_cmp++;
    if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_dack got d_ack=%b if_ack=%b want 1 0", bus.d_ack, bus.if_ack);
    end
    if (bus.d_ack && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.d_rdata !== e.data) begin
        n_bad++;
        $display("FAIL cancel_drdata got %h want %h", bus.d_rdata, e.data);
      end
    end
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) cyc();
  endtask
  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    bus.mem_ready = 1'b0;
    bus.if_addr   = 32'h14;
    bus.if_req    = 1'b1;
    cyc();
    n_cmp++;
    if (dut.state_q !== FETCH || bus.mem_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_fetch got state=%0d valid=%b want FETCH 1", dut.state_q, bus.mem_valid);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({bus.if_ack, bus.d_ack, bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got %h want 0", {bus.if_ack, bus.d_ack, bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
    end
    n_cmp++;
    if (dut.state_q !== IDLE || dut.u_cnt.cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL rstmid_state got state=%0d streak=%0d want 0/0", dut.state_q, dut.u_cnt.cnt_q);
    end
    rst           = 1'b1;
    bus.if_addr   = 32'h18;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00A0_0113;
    sb.push_back(exp_t'{1'b1, 32'h00A0_0113});
    cyc();
    n_cmp++;
    if (bus.mem_valid !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h18) begin
      n_bad++;
      $display("FAIL rstmid_regrant got valid=%b read=%b addr=%h want 1 1 18", bus.mem_valid, bus.mem_read, bus.mem_addr);
    end
    cyc();
    n_cmp++;
    if (bus.if_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_ack got %b want 1", bus.if_ack);
    end
    if (bus.if_ack && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.if_rdata !== e.data) begin
        n_bad++;
        $display("FAIL rstmid_rdata got %h want %h", bus.if_rdata, e.data);
      end
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) cyc();
  endtask
  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_cancel = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_funct3  = '0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_load_wait();
    test_fairness();
    test_store_cancel();
    test_cancel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
